// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register writeback block: regfile write-enable
// encoding, register address/data widths and the result record carried
// through the load buffer.
package reg_writeback_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  // Same write-enable encoding the regfile decodes on its write port
  localparam logic REG_WRITE_EN  = 1'b1;
  localparam logic REG_WRITE_DIS = 1'b0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t rd;
    reg_data_t data;
  } wb_result_t;

  // Decode a destination register to a one-hot scoreboard mask; x0 never
  // produces a bit because it is hardwired to zero in the regfile
  function automatic logic [31:0] reg_onehot(input reg_addr_t rd);
    logic [31:0] mask;
    mask = 32'd1 << rd;
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/wb_ld_fifo.sv
// Small synchronous FIFO buffering completed load results until they win the
// regfile write port. The head is read straight from storage, so an entry
// pushed at an edge can only be popped from the following cycle onwards.
module wb_ld_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_push,
  input  wb_result_t i_entry,
  input  logic       i_pop,
  output wb_result_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_result_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_empty = (count == '0);

  // A full FIFO refuses a push even when the head is leaving this cycle
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;
  assign o_head  = mem[rd_ptr];

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy decides what is valid
  always_ff @(posedge i_clock) begin
    if (do_push) mem[wr_ptr] <= i_entry;
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback arbiter for the single regfile write port. ALU results normally
// win; load results wait in a small FIFO and are forced through once the head
// has lost arbitration STARVE_LIMIT cycles in a row. A 32-bit pending-write
// scoreboard lets decode stall on RAW/WAW hazards against in-flight writes.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_issue_valid,
  input  logic        i_issue_wb,
  input  logic [4:0]  i_issue_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic        o_stall,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  output logic        o_alu_ready,
  input  logic        i_ld_valid,
  input  logic [4:0]  i_ld_rd,
  input  logic [31:0] i_ld_data,
  output logic        o_ld_ready,
  output logic        o_readwrite,
  output logic [4:0]  o_writereg,
  output logic [31:0] o_writedata
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [31:0]   pending;
  logic [SW-1:0] starve_cnt;

  wb_result_t    ld_entry;
  wb_result_t    ld_head;
  logic          ld_full;
  logic          ld_empty;

  logic          starved;
  logic          alu_win;
  logic          ld_win;
  logic          have_win;
  reg_addr_t     win_rd;
  reg_data_t     win_data;
  logic          issue_accept;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;

  assign ld_entry   = '{rd: i_ld_rd, data: i_ld_data};
  assign o_ld_ready = ~ld_full;

  wb_ld_fifo #(
    .DEPTH (LD_FIFO_DEPTH)
  ) u_ld_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (i_ld_valid),
    .i_entry (ld_entry),
    .i_pop   (ld_win),
    .o_head  (ld_head),
    .o_full  (ld_full),
    .o_empty (ld_empty)
  );

  // Hazard check against outstanding writes; x0 sources and destinations never stall
  always_comb begin
    o_stall = i_issue_valid &
              (((i_rs1 != '0) & pending[i_rs1]) |
               ((i_rs2 != '0) & pending[i_rs2]) |
               (i_issue_wb & (i_issue_rd != '0) & pending[i_issue_rd]));
  end

  // Pick at most one source: ALU first unless the load head has waited too long
  always_comb begin
    starved     = (starve_cnt == STARVE_MAX);
    o_alu_ready = ~starved;
    alu_win     = i_alu_valid & ~starved;
    ld_win      = ~ld_empty & (starved | ~i_alu_valid);
    have_win    = alu_win | ld_win;
    win_rd      = ld_win ? ld_head.rd   : i_alu_rd;
    win_data    = ld_win ? ld_head.data : i_alu_data;
  end

  // Scoreboard update masks; x0 is filtered out inside reg_onehot
  always_comb begin
    issue_accept = i_issue_valid & i_issue_wb & ~o_stall;
    set_mask     = issue_accept ? reg_onehot(i_issue_rd) : '0;
    clr_mask     = have_win ? reg_onehot(win_rd) : '0;
  end

  // Pending bits clear as their write is registered; a same-edge reissue keeps the bit set
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  // Count how long a waiting load head has been passed over, saturating at the limit
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      starve_cnt <= '0;
    end else if (ld_empty | ld_win) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Register the winning write for one cycle; writes to x0 are swallowed and address/data hold
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_readwrite <= REG_WRITE_DIS;
      o_writereg  <= '0;
      o_writedata <= '0;
    end else if (have_win && (win_rd != '0)) begin
      o_readwrite <= REG_WRITE_EN;
      o_writereg  <= win_rd;
      o_writedata <= win_data;
    end else begin
      o_readwrite <= REG_WRITE_DIS;
    end
  end

endmodule
